// File: rtl/input_conditioner.sv
// Async pin conditioner: two-flop synchronizer, strobe prescaler and
// strobe-sampled debouncer with registered edge pulses.
module input_conditioner #(
  parameter int PRESCALE = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  output logic d,
  output logic clk_en,
  output logic rise,
  output logic fall,
  output logic stable
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SETTLE = 1'b1;

  logic          sync1;
  logic          sync2;
  logic [PW-1:0] pcnt;
  logic [DW-1:0] dcnt;
  logic [0:0]    state;
  logic          differ;
  logic          accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (pcnt == PMAX) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Gated by rst so PRESCALE=1 still shows no strobe during reset
  assign clk_en = ~rst & (pcnt == PMAX);

  assign differ = (sync2 != d);
  assign accept = clk_en & differ &
                  (((state == IDLE) && (DEBOUNCE == 1)) ||
                   ((state == SETTLE) && (dcnt == DMAX)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dcnt  <= '0;
      d     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (accept) begin
        d     <= sync2;
        rise  <= sync2;
        fall  <= ~sync2;
        state <= IDLE;
        dcnt  <= '0;
      end else if (clk_en) begin
        unique case (state)
          IDLE: begin
            if (differ) begin
              state <= SETTLE;
              dcnt  <= DW'(1);
            end
          end
          SETTLE: begin
            if (!differ) begin
              state <= IDLE;
              dcnt  <= '0;
            end else begin
              dcnt <= dcnt + DW'(1);
            end
          end
        endcase
      end
    end
  end

  assign stable = (state == IDLE);

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter PRESCALE, default 4, clk cycles per clk_en strobe; legal range 1..256.
REQ-002 Parameter DEBOUNCE, default 3, consecutive differing strobe samples required to accept a new level; legal range 1..256.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 din_raw  input  1  asynchronous raw input (switch/pin); no timing relation to clk.
REQ-006 d  output  1  synchronized, debounced level; drives the downstream enabled flip-flop data input.
REQ-007 clk_en  output  1  periodic one-cycle strobe; drives the downstream flip-flop clock enable.
REQ-008 rise  output  1  one-cycle pulse when d changes 0->1.
REQ-009 fall  output  1  one-cycle pulse when d changes 1->0.
REQ-010 stable  output  1  high when the FSM is in IDLE (no pending level change).

Function
REQ-011 Synchronizer: two-flop chain sync1 <- din_raw, sync2 <- sync1; only sync2 is used internally.
REQ-012 Prescaler: counter pcnt counts 0..PRESCALE-1, wraps to 0; clk_en = (pcnt == PRESCALE-1), decoded from the registered counter only.
REQ-013 PRESCALE=1: clk_en high on every cycle while rst is low.
REQ-014 Debouncer FSM states: IDLE (sync2 == d), SETTLE (sync2 != d, counting); state and debounce counter dcnt change only on cycles with clk_en high.
REQ-015 IDLE, strobe, sync2 != d: if DEBOUNCE=1 accept immediately (REQ-017); else go SETTLE, dcnt <= 1.
REQ-016 SETTLE, strobe, sync2 == d: go IDLE, dcnt <= 0; no change to d, no pulse.
REQ-017 SETTLE, strobe, sync2 != d and dcnt == DEBOUNCE-1: d <= sync2, go IDLE, dcnt <= 0, and rise or fall high for exactly the following cycle.
REQ-018 SETTLE, strobe, sync2 != d and dcnt < DEBOUNCE-1: dcnt <= dcnt+1.
REQ-019 Net rule: d takes a new value only after DEBOUNCE consecutive strobes on which sync2 differs from d; any agreeing strobe restarts the count.
REQ-020 Latency from din_raw step (held) to d change: at most 2 + DEBOUNCE*PRESCALE cycles, at least 2 + (DEBOUNCE-1)*PRESCALE + 1.
REQ-021 rise and fall are registered, never high simultaneously, each high for exactly one cycle per accepted change, and coincident with the first cycle d shows its new value.
REQ-022 Counter widths: pcnt and dcnt sized clog2 of their parameter (minimum 1 bit); no overflow or wrap beyond the defined ranges.
REQ-023 Non-strobe cycles: FSM, dcnt, d hold; rise/fall low.

Reset
REQ-024 While rst is high, independent of clk: sync1=0, sync2=0, pcnt=0, dcnt=0, state=IDLE, d=0, rise=0, fall=0, stable=1, clk_en=0 (forced low during reset, including PRESCALE=1).
REQ-025 After rst deasserts, pcnt begins counting on the first rising edge; first clk_en is high in the cycle after the (PRESCALE-1)th edge (PRESCALE=4: after the 3rd edge), then every PRESCALE cycles.
REQ-026 rst asserted mid-SETTLE abandons the pending change: d=0, no rise/fall pulse is emitted on release.

Verification
REQ-027 Reset/prescale (PRESCALE=4): hold rst 3 cycles, release -> all outputs 0, stable=1; clk_en high one cycle after 3rd edge, then period 4, duty one cycle.
REQ-028 Clean step (PRESCALE=4, DEBOUNCE=3): din_raw 0->1 held -> d=1 within 14 cycles, rise high exactly one cycle, fall never, stable low during SETTLE then 1.
REQ-029 Glitch reject: din_raw high long enough for sync2 to be high on 2 strobes only, then low -> d stays 0, no rise, stable returns 1.
REQ-030 Bounce: din_raw toggles every cycle for 20 cycles then holds 1 -> exactly one rise pulse, d=1, no fall; then hold 0 -> exactly one fall, d=0.
REQ-031 Reset mid-operation: assert rst while in SETTLE with dcnt=2, between clock edges -> outputs take reset values immediately; after release, din_raw held 1 needs full 3 strobes again.
REQ-032 PRESCALE=1, DEBOUNCE=1: clk_en constant 1 after release; din_raw step reaches d in 3 cycles with one rise pulse.
